// File: rtl/text_buffer_if.sv
// Byte-stream handshake into the text buffer: the producer (UART receiver or
// keyboard decoder) drives valid/data, the buffer answers with ready.
interface text_buffer_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;

  modport master (output char_valid, char_data, input  char_ready);
  modport slave  (input  char_valid, char_data, output char_ready);
endinterface

// File: rtl/text_buffer.sv
// COLS x ROWS screen of 7-bit ASCII codes with cursor, wrap, BS/CR/FF handling
// and a registered pixel-to-character lookup. Optional macro: CURSOR_BLINK_EN.
module text_buffer #(
  parameter int COLS         = 32,
  parameter int ROWS         = 4,
  parameter int X0           = 192,
  parameter int Y0           = 208,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  text_buffer_if.slave            char_bus,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  output logic [6:0]              ascii_code,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic [$clog2(ROWS)-1:0] cursor_row
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int AW    = CW + RW;
  localparam int DEPTH = COLS * ROWS;

  localparam logic [6:0]  SPACE = 7'h20;
  localparam logic [9:0]  X_LO  = 10'(X0);
  localparam logic [9:0]  Y_LO  = 10'(Y0);
  localparam logic [10:0] X_HI  = 11'(X0 + 8 * COLS);
  localparam logic [10:0] Y_HI  = 11'(Y0 + 16 * ROWS);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;
  logic [AW-1:0] cur_q, cur_d;   // cursor as a linear address {row, col}
  logic          we;
  logic [AW-1:0] waddr;
  logic [6:0]    wdata;
  logic          fire;
  logic [7:0]    din;

  assign char_bus.char_ready = (state_q == IDLE);
  assign fire       = char_bus.char_valid && char_bus.char_ready;
  assign din        = char_bus.char_data;
  assign cursor_col = cur_q[CW-1:0];
  assign cursor_row = cur_q[AW-1:CW];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      clr_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      cur_q   <= cur_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statements can infer a latch.
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    cur_d   = cur_q;
    we      = 1'b0;
    waddr   = cur_q;
    wdata   = SPACE;
    case (state_q)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_q;
        clr_d = clr_q + 1'b1;
        if (clr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          cur_d   = '0;
        end
      end
      IDLE: begin
        if (fire) begin
          if (din >= 8'h20 && din <= 8'h7E) begin
            we    = 1'b1;
            wdata = din[6:0];
            // Linear increment gives col wrap, row advance and screen wrap.
            cur_d = cur_q + 1'b1;
          end else begin
            case (din)
              8'h08: begin
                cur_d = (cur_q == '0) ? '0 : cur_q - 1'b1;
                we    = 1'b1;
                waddr = cur_d;
              end
              8'h0D: cur_d = {cur_q[AW-1:CW] + 1'b1, {CW{1'b0}}};
              8'h0C: begin
                state_d = CLEAR;
                clr_d   = '0;
                cur_d   = '0;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Pixel to cell: window compare on the raw coordinates, before any shift.
  logic [9:0]    dx, dy;
  logic [CW-1:0] rd_col;
  logic [RW-1:0] rd_row;
  logic [AW-1:0] raddr;
  logic          in_win, in_win_q;
  logic [6:0]    rd_q;

  assign dx     = x - X_LO;
  assign dy     = y - Y_LO;
  assign rd_col = CW'(dx >> 3);
  assign rd_row = RW'(dy >> 4);
  assign raddr  = {rd_row, rd_col};
  assign in_win = (x >= X_LO) && ({1'b0, x} < X_HI) &&
                  (y >= Y_LO) && ({1'b0, y} < Y_HI);

  logic [6:0] mem [DEPTH];

  // NOTE: the character RAM has no reset; CLEAR initialises it by walking
  // every address, which keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_q <= mem[raddr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_win_q <= 1'b0;
    else       in_win_q <= in_win;
  end

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          blink_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
      blink_q   <= 1'b0;
    end else begin
      if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      blink_q <= phase && (state_q == IDLE) && in_win && (raddr == cur_q);
    end
  end

  assign ascii_code = blink_q ? 7'h5F : (in_win_q ? rd_q : SPACE);
`else
  assign ascii_code = in_win_q ? rd_q : SPACE;
`endif

endmodule

// File: tb/tb_text_buffer.sv
// Randomised self-checking bench for text_buffer against a screen/cursor model
// built from plain arithmetic on (col, row); blink checks follow CURSOR_BLINK_EN.
module tb_text_buffer;

  localparam int COLS = 32;
  localparam int ROWS = 4;
  localparam int X0   = 192;
  localparam int Y0   = 208;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] px, py;
  logic [6:0] ascii_code;
  logic [4:0] cursor_col;
  logic [1:0] cursor_row;

  text_buffer_if cif ();

  text_buffer #(
    .COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0), .BLINK_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .char_bus(cif),
    .x(px), .y(py), .ascii_code(ascii_code),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] scr [COLS*ROWS];
  int mcol, mrow;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < COLS*ROWS; i++) scr[i] = 7'h20;
    mcol = 0;
    mrow = 0;
  endtask

  task automatic model_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[mrow*COLS + mcol] = b[6:0];
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
      end
    end else if (b == 8'h08) begin
      if (mcol > 0) mcol--;
      else if (mrow > 0) begin
        mcol = COLS - 1;
        mrow--;
      end
      scr[mrow*COLS + mcol] = 7'h20;
    end else if (b == 8'h0D) begin
      mcol = 0;
      mrow = (mrow + 1) % ROWS;
    end else if (b == 8'h0C) begin
      model_reset();
    end
  endtask

  // Expected code for a pixel, and whether the pixel sits on the cursor cell.
  task automatic expect_px(input int xi, input int yi, output logic [6:0] e, output bit at_cur);
    at_cur = 1'b0;
    e      = 7'h20;
    if (xi >= X0 && xi < X0 + 8*COLS && yi >= Y0 && yi < Y0 + 16*ROWS) begin
      e      = scr[((yi - Y0) / 16) * COLS + (xi - X0) / 8];
      at_cur = ((xi - X0) / 8 == mcol) && ((yi - Y0) / 16 == mrow);
    end
  endtask

  task automatic check_code(input string tag, input logic [6:0] got, input logic [6:0] exp_in,
                            input bit at_cur);
    logic [6:0] e;
    e = exp_in;
`ifdef CURSOR_BLINK_EN
    if (at_cur && got == 7'h5F) e = 7'h5F;
`else
    if (at_cur) e = exp_in;
`endif
    check(tag, 32'(got), 32'(e));
  endtask

  task automatic read_px(input string tag, input int xi, input int yi);
    logic [6:0] e;
    bit at_cur;
    px = 10'(xi);
    py = 10'(yi);
    tick();
    expect_px(xi, yi, e, at_cur);
    check_code(tag, ascii_code, e, at_cur);
  endtask

  task automatic read_const(input string tag, input int xi, input int yi, input logic [6:0] e);
    px = 10'(xi);
    py = 10'(yi);
    tick();
    check(tag, 32'(ascii_code), 32'(e));
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_col"}, 32'(cursor_col), 32'(mcol));
    check({tag, "_row"}, 32'(cursor_row), 32'(mrow));
  endtask

  task automatic check_screen(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        read_px(tag, X0 + 8*c + int'($urandom_range(0, 7)), Y0 + 16*r + int'($urandom_range(0, 15)));
  endtask

  // Counts cycles of char_ready low; a CLEAR lasts exactly COLS*ROWS cycles.
  task automatic wait_clear(input string tag);
    int n = 0;
    while (!cif.char_ready && n < 1000) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(COLS*ROWS));
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!cif.char_ready && n < 1000) begin
      tick();
      n++;
    end
    if (!cif.char_ready) check("ready_timeout", 32'(cif.char_ready), 32'd1);
    cif.char_valid = 1'b1;
    cif.char_data  = b;
    tick();
    cif.char_valid = 1'b0;
    model_apply(b);
    if (b == 8'h0C) begin
      check("ff_ready_drop", 32'(cif.char_ready), 32'd0);
      wait_clear("ff_clear_len");
    end
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] b;
    r = int'($urandom_range(0, 99));
    if (r < 70)      b = 8'($urandom_range(32, 126));
    else if (r < 80) b = 8'h08;
    else if (r < 88) b = 8'h0D;
    else if (r < 89) b = 8'h0C;
    else begin
      b = 8'($urandom_range(0, 255));
      if ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0D || b == 8'h0C) b = 8'h7F;
    end
    return b;
  endfunction

  task automatic random_stream(input int len);
    for (int i = 0; i < len; i++) begin
      send(rand_byte());
      if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(1, 3))) tick();
    end
  endtask

  initial begin
    logic [6:0] old_code;
    int         n5f;
    bit         at_cur;

    reset          = 1'b1;
    cif.char_valid = 1'b0;
    cif.char_data  = 8'h00;
    px             = '0;
    py             = '0;
    model_reset();
    repeat (3) tick();
    check("rst_ready", 32'(cif.char_ready), 32'd0);
    check("rst_ascii", 32'(ascii_code), 32'h20);
    check_cursor("rst_cursor");

    reset = 1'b0;
    wait_clear("init_clear_len");
    check_screen("init_cell");
    read_const("origin_pixel", 0, 0, 7'h20);

    send(8'h48);
    send(8'h69);
    check("hi_col", 32'(cursor_col), 32'd2);
    check("hi_row", 32'(cursor_row), 32'd0);
    read_const("cell_H", 192, 208, 7'h48);
    read_const("cell_i", 200, 223, 7'h69);
    read_const("left_of_window", 191, 208, 7'h20);

    send(8'h0C);
    repeat (32) send(8'h41);
    check("row_wrap_col", 32'(cursor_col), 32'd0);
    check("row_wrap_row", 32'(cursor_row), 32'd1);
    send(8'h0D);
    check("cr_col", 32'(cursor_col), 32'd0);
    check("cr_row", 32'(cursor_row), 32'd2);
    read_const("last_col_A", 447, 208, 7'h41);
    read_const("row1_blank", 192, 224, 7'h20);

    send(8'h0C);
    repeat (32) send(8'h41);
    send(8'h08);
    check("bs_wrap_col", 32'(cursor_col), 32'd31);
    check("bs_wrap_row", 32'(cursor_row), 32'd0);
    read_const("bs_cell_blank", 440, 208, 7'h20);

    send(8'h0C);
    send(8'h08);
    check("bs_origin_col", 32'(cursor_col), 32'd0);
    check("bs_origin_row", 32'(cursor_row), 32'd0);

    for (int i = 0; i < COLS*ROWS; i++) send(8'($urandom_range(32, 126)));
    send(8'h5A);
    check("fill_wrap_col", 32'(cursor_col), 32'd1);
    check("fill_wrap_row", 32'(cursor_row), 32'd0);
    read_const("fill_Z", 195, 210, 7'h5A);
    check_screen("fill_cell");

    send(8'h0C);
    check_screen("ff_cell");
    check_cursor("ff_cursor");

    random_stream(300);
    check_cursor("rand_cursor");
    check_screen("rand_cell");
    for (int i = 0; i < 60; i++) begin
      if (i % 2 == 0) read_px("rand_px", int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      else read_px("edge_px", int'($urandom_range(150, 500)), int'($urandom_range(180, 300)));
    end

    // Read and write of the same cell in one cycle: old data first, new after.
    px = 10'(X0 + 8*mcol + 3);
    py = 10'(Y0 + 16*mrow + 5);
    old_code = scr[mrow*COLS + mcol];
    cif.char_valid = 1'b1;
    cif.char_data  = 8'h51;
    tick();
    cif.char_valid = 1'b0;
    check_code("rbw_old", ascii_code, old_code, 1'b1);
    model_apply(8'h51);
    tick();
    expect_px(int'(px), int'(py), old_code, at_cur);
    check_code("rbw_new", ascii_code, old_code, at_cur);

    // Cursor at (3,0): sample its cell for two full blink periods.
    send(8'h0C);
    send(8'h61);
    send(8'h62);
    send(8'h63);
    px  = 10'd216;
    py  = 10'd208;
    n5f = 0;
    tick();
    for (int i = 0; i < 16; i++) begin
      if (ascii_code == 7'h5F) n5f++;
      else check("blink_stored", 32'(ascii_code), 32'h20);
      tick();
    end
`ifdef CURSOR_BLINK_EN
    check("blink_count", 32'(n5f), 32'd8);
`else
    check("blink_count", 32'(n5f), 32'd0);
`endif

    // Reset in the middle of a byte stream.
    random_stream(20);
    send(8'h41);
    reset = 1'b1;
    #1;
    check("midstream_rst_ready", 32'(cif.char_ready), 32'd0);
    check("midstream_rst_ascii", 32'(ascii_code), 32'h20);
    model_reset();
    check_cursor("midstream_rst_cursor");
    tick();
    reset = 1'b0;
    wait_clear("midstream_clear_len");

    // Reset in the middle of a CLEAR.
    send(8'h42);
    cif.char_valid = 1'b1;
    cif.char_data  = 8'h0C;
    tick();
    cif.char_valid = 1'b0;
    model_apply(8'h0C);
    repeat (50) tick();
    reset = 1'b1;
    #1;
    check("midclear_rst_ready", 32'(cif.char_ready), 32'd0);
    check_cursor("midclear_rst_cursor");
    tick();
    reset = 1'b0;
    wait_clear("midclear_clear_len");
    check_screen("midclear_cell");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/text_buffer.md
Name: text_buffer

Overview:
- Character store feeding the text overlay stage's ascii_code input; sits directly upstream of the glyph/ROM rendering stage.
- Accepts a byte stream (UART receiver or keyboard decoder) and maintains a COLS x ROWS screen of 7-bit ASCII codes with cursor, wrap, backspace, carriage return and clear-screen.
- For the current pixel (x, y), returns the code of the character cell covering that pixel.
- The text window is 256x64 px at (192,208), made of 32x4 cells of 8x16 px.

Parameters:
- COLS, 32, characters per row (power of 2)
- ROWS, 4, rows of characters (power of 2)
- X0, 192, left pixel column of text window
- Y0, 208, top pixel row of text window
- BLINK_CYCLES, 25000000, clk cycles per cursor blink half-period (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- char_valid  in  1  char_data holds a byte to consume
- char_data  in  8  incoming byte
- char_ready  out  1  block can accept a byte this cycle
- x  in  10  current pixel column
- y  in  10  current pixel row
- ascii_code  out  7  character code for cell under (x, y)
- cursor_col  out  log2(COLS)  current write column
- cursor_row  out  log2(ROWS)  current write row

Behaviour:
- Interface: one clock, clk; asynchronous active-high reset, reset.
- Storage: COLS*ROWS x 7-bit RAM, one write port and one synchronous read port. The RAM is not reset.
- Reset values: ascii_code=7'h20, char_ready=0, cursor_col=0, cursor_row=0, FSM state=CLEAR, clear address=0.
- FSM states:
  - CLEAR: write 7'h20 at clear address, then increment. After the write to address COLS*ROWS-1, go to IDLE with cursor (0,0). char_ready=0 throughout. Duration is exactly COLS*ROWS cycles.
  - IDLE: char_ready=1. A byte is consumed only when char_valid && char_ready; each consumed byte is processed in that same cycle.
- Byte handling in IDLE:
  - Printable, 0x20..0x7E: write char_data[6:0] at the cursor, then advance the cursor.
  - Advance: col+1. From col COLS-1, go to col 0 and row+1. From (COLS-1, ROWS-1), wrap to (0,0). No scrolling.
  - 0x08 backspace: move the cursor back one cell and write 7'h20 there.
    - From col 0 with row>0: move to (COLS-1, row-1).
    - At (0,0): cursor stays and 7'h20 is written at (0,0).
  - 0x0D carriage return: go to col 0 of the next row; from the last row, go to row 0. No RAM write.
  - 0x0C form feed: go to CLEAR; char_ready drops the next cycle.
  - Any other byte, including 0x7F and >=0x80: consumed with no effect.
- Read path:
  - In window when X0 <= x < X0+8*COLS and Y0 <= y < Y0+16*ROWS.
  - col = (x-X0)>>3, row = (y-Y0)>>4, read address = row*COLS+col.
  - ascii_code is registered, with 1 clk latency from x/y. Outside the window, ascii_code=7'h20 after the same latency.
  - Subtraction is 10-bit; the window compare is done before the shift, so there is no negative-underflow aliasing.
- Simultaneous write and read of the same address: read returns the old data (read-before-write). The new value is visible the next cycle.
- Reset asserted mid-CLEAR or mid-stream: immediately returns to the reset values, and a full CLEAR restarts after release.

Optional Feature:
- Macro: CURSOR_BLINK_EN.
- Defined:
  - Counter 0..BLINK_CYCLES-1 toggles a phase bit on wrap; phase resets to 1.
  - When phase=1, state=IDLE, and the read cell equals (cursor_col, cursor_row), ascii_code=7'h5F (underscore) instead of the stored code. Same latency.
- Undefined: no counter or phase logic; ascii_code is always the stored code.

Test Plan:
- Release reset -> char_ready=0 for exactly 128 cycles, then 1. Every in-window read returns 7'h20. x=0,y=0 -> 7'h20.
- Send 'H'(0x48),'i'(0x69) -> cursor (2,0). x=192,y=208 -> 7'h48 one cycle later; x=200,y=223 -> 7'h69; x=191,y=208 -> 7'h20.
- Send 32 'A' then 0x0D -> after 32 bytes cursor (0,1), after CR (0,2). x=447,y=208 -> 7'h41; x=192,y=224 -> 7'h20.
- Cursor (0,1), send 0x08 -> cursor (31,0), cell (31,0)=7'h20. Send 0x08 at (0,0) -> cursor stays (0,0).
- Fill all 128 cells, then send 'Z' -> written at (0,0), cursor (1,0). Send 0x0C -> char_ready=0 next cycle for 128 cycles; all cells 7'h20; cursor (0,0).
- CURSOR_BLINK_EN, BLINK_CYCLES=4, cursor (3,0) -> reads at x=216,y=208 alternate 7'h5F / stored code every 4 cycles. Without the macro -> always the stored code.
